// File: rtl/ext_load_pipe_if.sv
// rtl/ext_load_pipe_if.sv - request/result bundle for the extension/load pipeline
interface ext_load_pipe_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [2:0]       op;
  logic [1:0]       addr;
  logic [31:0]      din;
  logic [15:0]      imm16;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [31:0]      dout;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, op, addr, din, imm16, stall, flush,
    input  out_valid, dout, out_err, err_count
  );

  modport slave (
    input  in_valid, op, addr, din, imm16, stall, flush,
    output out_valid, dout, out_err, err_count
  );
endinterface

// File: rtl/ext_load_pipe.sv
// rtl/ext_load_pipe.sv - pipelined immediate/load-data extension with misalignment tracking
module ext_load_pipe #(
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  ext_load_pipe_if.slave bus
);

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_LBU  = 3'b001;
  localparam logic [2:0] OP_LB   = 3'b010;
  localparam logic [2:0] OP_LHU  = 3'b011;
  localparam logic [2:0] OP_LH   = 3'b100;
  localparam logic [2:0] OP_ZEXT = 3'b101;
  localparam logic [2:0] OP_SEXT = 3'b110;
  localparam logic [2:0] OP_LUI  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      data_d;
  logic             err_d;

  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   err_q;
  logic [31:0]      data_q [LAT];

  logic             retire;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stage-0 extraction/extension; a misaligned access zeroes its data.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = bus.addr[1] ? bus.din[31:16] : bus.din[15:0];
    data_d   = 32'h0;
    err_d    = 1'b0;
    case (bus.addr)
      2'd0:    byte_sel = bus.din[7:0];
      2'd1:    byte_sel = bus.din[15:8];
      2'd2:    byte_sel = bus.din[23:16];
      default: byte_sel = bus.din[31:24];
    endcase
    case (bus.op)
      OP_LW: begin
        if (bus.addr != 2'd0) err_d = 1'b1;
        else                  data_d = bus.din;
      end
      OP_LBU:  data_d = {24'h0, byte_sel};
      OP_LB:   data_d = {{24{byte_sel[7]}}, byte_sel};
      OP_LHU: begin
        if (bus.addr[0]) err_d = 1'b1;
        else             data_d = {16'h0, half_sel};
      end
      OP_LH: begin
        if (bus.addr[0]) err_d = 1'b1;
        else             data_d = {{16{half_sel[15]}}, half_sel};
      end
      OP_ZEXT: data_d = {16'h0, bus.imm16};
      OP_SEXT: data_d = {{16{bus.imm16[15]}}, bus.imm16};
      OP_LUI:  data_d = {bus.imm16, 16'h0};
      default: data_d = 32'h0;
    endcase
  end

  // Stage shift register: reset beats flush beats stall; flush only clears valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < LAT; k++) data_q[k] <= 32'h0;
    end else if (bus.flush) begin
      vld_q <= '0;
    end else if (!bus.stall) begin
      vld_q[0]  <= bus.in_valid;
      err_q[0]  <= err_d;
      data_q[0] <= data_d;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k]  <= vld_q[k-1];
        err_q[k]  <= err_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  // The output entry leaves only on a non-stalled cycle, so a held entry counts once.
  assign retire = vld_q[LAT-1] & ~bus.stall;

  // Saturating increment for each retiring errored entry.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && err_q[LAT-1] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.dout      = vld_q[LAT-1] ? data_q[LAT-1] : 32'h0;
  assign bus.out_err   = vld_q[LAT-1] & err_q[LAT-1];
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_ext_load_pipe.sv
// tb/tb_ext_load_pipe.sv - directed bench for ext_load_pipe at LAT=1, LAT=3 and CNT_W=2
module tb_ext_load_pipe;

  logic clk = 1'b0;
  logic rst1, rst2, rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ext_load_pipe_if #(.CNT_W(8)) if1 ();
  ext_load_pipe_if #(.CNT_W(2)) if2 ();
  ext_load_pipe_if #(.CNT_W(8)) if3 ();

  ext_load_pipe #(.LAT(1), .CNT_W(8)) u1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  ext_load_pipe #(.LAT(1), .CNT_W(2)) u2 (.clk(clk), .reset(rst2), .bus(if2.slave));
  ext_load_pipe #(.LAT(3), .CNT_W(8)) u3 (.clk(clk), .reset(rst3), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input logic [2:0] op, input logic [1:0] addr,
                       input logic [31:0] din, input logic [15:0] imm,
                       input logic [31:0] exp_d, input logic exp_e, input logic [7:0] exp_c);
    if1.in_valid = 1'b1;
    if1.op       = op;
    if1.addr     = addr;
    if1.din      = din;
    if1.imm16    = imm;
    tick();
    chk({tag, "_valid"}, {31'h0, if1.out_valid}, 32'h1);
    chk({tag, "_dout"},  if1.dout, exp_d);
    chk({tag, "_err"},   {31'h0, if1.out_err}, {31'h0, exp_e});
    chk({tag, "_cnt"},   {24'h0, if1.err_count}, {24'h0, exp_c});
  endtask

  task automatic set3(input logic v, input logic [2:0] op, input logic [1:0] addr,
                      input logic [31:0] din, input logic [15:0] imm);
    if3.in_valid = v;
    if3.op       = op;
    if3.addr     = addr;
    if3.din      = din;
    if3.imm16    = imm;
  endtask

  task automatic out3(input string tag, input logic v, input logic [31:0] d,
                      input logic e, input logic [7:0] c);
    chk({tag, "_valid"}, {31'h0, if3.out_valid}, {31'h0, v});
    chk({tag, "_dout"},  if3.dout, d);
    chk({tag, "_err"},   {31'h0, if3.out_err}, {31'h0, e});
    chk({tag, "_cnt"},   {24'h0, if3.err_count}, {24'h0, c});
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    if1.in_valid = 1'b0; if1.op = 3'b0; if1.addr = 2'b0; if1.din = 32'h0; if1.imm16 = 16'h0;
    if1.stall = 1'b0; if1.flush = 1'b0;
    if2.in_valid = 1'b0; if2.op = 3'b0; if2.addr = 2'b0; if2.din = 32'h0; if2.imm16 = 16'h0;
    if2.stall = 1'b0; if2.flush = 1'b0;
    if3.in_valid = 1'b0; if3.op = 3'b0; if3.addr = 2'b0; if3.din = 32'h0; if3.imm16 = 16'h0;
    if3.stall = 1'b0; if3.flush = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_u1_valid", {31'h0, if1.out_valid}, 32'h0);
    chk("rst_u1_dout",  if1.dout, 32'h0);
    chk("rst_u1_cnt",   {24'h0, if1.err_count}, 32'h0);
    chk("rst_u2_valid", {31'h0, if2.out_valid}, 32'h0);
    chk("rst_u3_valid", {31'h0, if3.out_valid}, 32'h0);
    chk("rst_u3_cnt",   {24'h0, if3.err_count}, 32'h0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

    // LAT=1 back-to-back loads, immediates, then misaligned accesses
    step1("lw_a0",   3'b000, 2'd0, 32'h80FF1234, 16'h0,    32'h80FF1234, 1'b0, 8'd0);
    step1("lb_a3",   3'b010, 2'd3, 32'h80FF1234, 16'h0,    32'hFFFFFF80, 1'b0, 8'd0);
    step1("lbu_a3",  3'b001, 2'd3, 32'h80FF1234, 16'h0,    32'h00000080, 1'b0, 8'd0);
    step1("lh_a2",   3'b100, 2'd2, 32'h80FF1234, 16'h0,    32'hFFFF80FF, 1'b0, 8'd0);
    step1("lhu_a2",  3'b011, 2'd2, 32'h80FF1234, 16'h0,    32'h000080FF, 1'b0, 8'd0);
    step1("lb_a1",   3'b010, 2'd1, 32'h80FF1234, 16'h0,    32'h00000012, 1'b0, 8'd0);
    step1("lh_a0",   3'b100, 2'd0, 32'h80FF1234, 16'h0,    32'h00001234, 1'b0, 8'd0);
    step1("zext",    3'b101, 2'd3, 32'h80FF1234, 16'h8001, 32'h00008001, 1'b0, 8'd0);
    step1("sext",    3'b110, 2'd1, 32'h80FF1234, 16'h8001, 32'hFFFF8001, 1'b0, 8'd0);
    step1("lui",     3'b111, 2'd2, 32'h80FF1234, 16'h8001, 32'h80010000, 1'b0, 8'd0);
    step1("mis_lw",  3'b000, 2'd2, 32'h80FF1234, 16'h0,    32'h00000000, 1'b1, 8'd0);
    step1("mis_lh",  3'b100, 2'd1, 32'h80FF1234, 16'h0,    32'h00000000, 1'b1, 8'd1);
    step1("mis_lhu", 3'b011, 2'd3, 32'h80FF1234, 16'h0,    32'h00000000, 1'b1, 8'd2);

    // errored entry held at the output for three stalled cycles
    if1.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_valid", {31'h0, if1.out_valid}, 32'h1);
      chk("stall_hold_err",   {31'h0, if1.out_err}, 32'h1);
      chk("stall_hold_cnt",   {24'h0, if1.err_count}, 32'd2);
    end
    if1.stall = 1'b0;
    if1.in_valid = 1'b0;
    tick();
    chk("after_stall_valid", {31'h0, if1.out_valid}, 32'h0);
    chk("after_stall_dout",  if1.dout, 32'h0);
    chk("after_stall_err",   {31'h0, if1.out_err}, 32'h0);
    chk("after_stall_cnt",   {24'h0, if1.err_count}, 32'd3);
    tick();
    chk("idle_cnt",          {24'h0, if1.err_count}, 32'd3);

    // LAT=3: exact latency, stall mid-stream, flush with in_valid=1
    set3(1'b1, 3'b001, 2'd0, 32'h12345678, 16'h0);     // A: lbu -> 00000078
    tick(); out3("l3_e1", 1'b0, 32'h0, 1'b0, 8'd0);
    set3(1'b1, 3'b000, 2'd1, 32'h12345678, 16'h0);     // B: misaligned lw
    tick(); out3("l3_e2", 1'b0, 32'h0, 1'b0, 8'd0);
    set3(1'b1, 3'b100, 2'd0, 32'h00008000, 16'h0);     // C: lh -> FFFF8000
    tick(); out3("l3_A",  1'b1, 32'h00000078, 1'b0, 8'd0);
    set3(1'b1, 3'b111, 2'd0, 32'h0, 16'h1234);         // D: lui -> 12340000
    tick(); out3("l3_B",  1'b1, 32'h00000000, 1'b1, 8'd0);
    if3.stall = 1'b1;
    set3(1'b1, 3'b101, 2'd0, 32'h0, 16'hFFFF);         // ignored while stalled
    tick(); out3("l3_stall1", 1'b1, 32'h00000000, 1'b1, 8'd0);
    tick(); out3("l3_stall2", 1'b1, 32'h00000000, 1'b1, 8'd0);
    if3.stall = 1'b0;
    if3.flush = 1'b1;
    set3(1'b1, 3'b110, 2'd0, 32'h0, 16'h8000);
    tick(); out3("l3_flush", 1'b0, 32'h0, 1'b0, 8'd1);
    if3.flush = 1'b0;
    set3(1'b0, 3'b000, 2'd0, 32'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); out3("l3_drained", 1'b0, 32'h0, 1'b0, 8'd1);
    end

    // LAT=3: reset with two entries in flight while stalled
    set3(1'b1, 3'b000, 2'd0, 32'hCAFEF00D, 16'h0);
    tick();
    set3(1'b1, 3'b000, 2'd3, 32'hCAFEF00D, 16'h0);
    tick();
    set3(1'b0, 3'b000, 2'd0, 32'h0, 16'h0);
    if3.stall = 1'b1;
    rst3 = 1'b1;
    tick(); out3("l3_rst", 1'b0, 32'h0, 1'b0, 8'd0);
    rst3 = 1'b0;
    if3.stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); out3("l3_post_rst", 1'b0, 32'h0, 1'b0, 8'd0);
    end

    // CNT_W=2 saturation over five misaligned retirements
    if2.in_valid = 1'b1;
    if2.op       = 3'b000;
    if2.addr     = 2'd1;
    if2.din      = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_err", {31'h0, if2.out_err}, 32'h1);
      chk("sat_cnt", {30'h0, if2.err_count}, (i > 3) ? 32'd3 : i);
    end
    if2.in_valid = 1'b0;
    tick();
    chk("sat_final_cnt",   {30'h0, if2.err_count}, 32'd3);
    chk("sat_final_valid", {31'h0, if2.out_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_load_pipe.md
Name: ext_load_pipe

Overview:
Parametrised, pipelined extension unit for the datapath. It handles the immediate-extension modes (zero, sign, lui) and the load-data extraction and extension for lw/lb/lbu/lh/lhu, with byte-lane select from the address.
- Results pass through LAT register stages with valid, stall and flush control, so the block drops into the M/W boundary of the 5-stage pipeline.
- Misaligned accesses raise an error flag.
- A saturating counter records how many errored operations have retired.

Parameters:
LAT, 1, number of register stages from input acceptance to output (legal 1..4).
CNT_W, 8, width of the saturating misalignment counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  the op/addr/din/imm16 inputs are valid this cycle.
op  input  3  operation: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, 101 zero-extend imm16, 110 sign-extend imm16, 111 lui.
addr  input  2  byte offset (address bits [1:0]) for load ops; ignored for ops 101..111.
din  input  32  word read from data memory.
imm16  input  16  immediate field.
stall  input  1  hold every stage; inputs are not sampled.
flush  input  1  invalidate all in-flight entries.
out_valid  output  1  dout/out_err are valid.
dout  output  32  extended result.
out_err  output  1  the retiring op was misaligned.
err_count  output  CNT_W  saturating count of retired misaligned ops.

Behaviour:
- Reset (synchronous, clk edge with reset=1): all stage valid bits, dout, out_err and err_count go to 0. Reset has priority over stall and flush. Reset in mid-operation discards all in-flight entries.
- Stage 0 combinational compute from the inputs:
  - lw: dout=din.
  - lbu/lb: byte = din[8*addr+7 : 8*addr] (little-endian); lbu zero-extends to 32, lb sign-extends from bit 7.
  - lhu/lh: half = addr[1] ? din[31:16] : din[15:0]; lhu zero-extends, lh sign-extends from bit 15.
  - 101: {16'h0, imm16}.
  - 110: {{16{imm16[15]}}, imm16}.
  - 111: {imm16, 16'h0}.
- Misalignment:
  - lw with addr!=0 is misaligned; lh/lhu with addr[0]=1 is misaligned.
  - A misaligned op sets err=1 and forces its data to 32'h0.
  - Byte ops and ops 101..111 never error.
- Pipeline, per clk edge with reset=0:
  - flush=1: all valid bits go to 0. Flush wins over in_valid and stall. Data and err registers may keep stale values but are masked by valid.
  - stall=1, flush=0: every stage holds (valid, data, err).
  - stall=0, flush=0: stage0 <= {in_valid, computed data, err}; stage k <= stage k-1 for k=1..LAT-1.
- Latency: an op accepted at edge N (in_valid=1, stall=0, flush=0) appears on the outputs after edge N+LAT-1, i.e. LAT edges counted from its acceptance edge, assuming no stall.
- Outputs:
  - out_valid, dout and out_err are driven directly from the last stage registers.
  - When out_valid=0, dout and out_err read 0; the output is masked.
- Retire and counter:
  - The output entry retires in any cycle with out_valid=1 and stall=0, whether or not flush is asserted.
  - err_count increments by 1 on retire with out_err=1.
  - err_count saturates at all-ones and is cleared only by reset.
  - A stalled errored entry is counted exactly once.
- Throughput: one op per cycle with no bubbles when stall=0.
- Upstream must hold its inputs while stall=1; in_valid during stall is ignored, not queued.

Test Plan:
- LAT=1, reset, then din=32'h80FF1234 with the ops lw/addr0, lb/addr3, lbu/addr3, lh/addr2, lhu/addr2, issued back-to-back -> dout = 80FF1234, FFFFFF80, 00000080, FFFF80FF, 000080FF on consecutive cycles with out_valid continuous and out_err=0.
- imm16=16'h8001 with ops 101, 110, 111 -> 00008001, FFFF8001, 80010000.
- Misalignment: lw/addr2, lh/addr1, lhu/addr3 -> out_err=1 and dout=0 for each; err_count reaches 3. Then hold stall=1 for 3 cycles with an errored entry at the output -> err_count increments only once.
- LAT=3: issue 4 ops, assert stall for 2 cycles mid-stream, then flush for 1 cycle with in_valid=1 -> latency is exactly 3 edges from acceptance; stalled entries are preserved; all entries behind the output stage and the flush-cycle input are dropped; out_valid=0 on the following cycles.
- CNT_W=2: retire 5 misaligned ops -> err_count goes 1, 2, 3, 3, 3.
- Assert reset mid-stream with 2 entries in flight and stall=1 -> the next cycle has out_valid=0, dout=0, err_count=0, and no stale output after reset is released.
